disp_scan: RTL and testbench
============================

Name: disp_scan

Overview:
- Time-multiplexed scan controller for the two-digit 7-segment display.
- Sits directly upstream of the segment decoder. It synchronizes the 4-bit switch value, freezes it per refresh frame, and drives the decoder's 4-bit value input and its units/tens select.
- Also drives the two active-low digit anodes, alternating units and tens with a dead-time gap between them to prevent ghosting.

Parameters:
- DIGIT_CYCLES, 50000: clock cycles each digit is lit; must be >= 2.
- GAP_CYCLES, 500: clock cycles both anodes are off between digits; must be >= 1.
- SYNC_STAGES, 2: flip-flop stages in the switch synchronizer; must be >= 2.

Ports:
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  synchronous reset, active-high.
- sw_in  in  4  asynchronous switch inputs (binary 0..15).
- val_out  out  4  frame-frozen value fed to the segment decoder's value input.
- sel_units  out  1  digit select to the decoder: 1 = units nibble, 0 = tens nibble.
- an0  out  1  units-digit anode, active-low (0 = lit).
- an1  out  1  tens-digit anode, active-low (0 = lit).
- frame_start  out  1  one-cycle pulse on every entry to S_GAP_TU, including the entry made by reset.

Behaviour:
- Interface is decided: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registers. They change on the same edge that enters a state, so there is no decode glitching.
- Synchronizer: each sw_in bit passes through SYNC_STAGES flops. sync_val is the last stage. There is no debounce.
- FSM states, in cycle order:
  - S_GAP_TU: GAP_CYCLES cycles, then go to S_DIG_U.
  - S_DIG_U: DIGIT_CYCLES cycles, then go to S_GAP_UT.
  - S_GAP_UT: GAP_CYCLES cycles, then go to S_DIG_T.
  - S_DIG_T: DIGIT_CYCLES cycles, then go to S_GAP_TU.
- Dwell counter: counts 0..N-1 in each state and transitions when count == N-1. It clears to 0 on every transition.
- Frame period is exactly 2*(DIGIT_CYCLES+GAP_CYCLES) cycles.
- Outputs per state:
  - S_DIG_U: an0=0, an1=1.
  - S_DIG_T: an0=1, an1=0.
  - Both gap states: an0=an1=1. The two anodes are never 0 together.
- sel_units changes only on gap entry, so the decoder mux settles while the anodes are dark:
  - becomes 0 on entering S_GAP_UT;
  - becomes 1 on entering S_GAP_TU.
- val_out loads sync_val only on entry to S_GAP_TU. Switch changes mid-frame never tear a displayed pair.
- frame_start is 1 for exactly the cycle after that entry edge.
- Reset (any cycle, including mid-frame):
  - On the next edge: state=S_GAP_TU, count=0, val_out=0, sel_units=1, an0=1, an1=1, frame_start=1, all synchronizer flops=0.
  - First lit cycle (an0=0) occurs GAP_CYCLES cycles after the first edge with rst=0.
- Width rules:
  - Dwell counter width = $clog2(max(DIGIT_CYCLES,GAP_CYCLES)).
  - Tens-zero detect is val_out < 4'd10 (unsigned compare).
- Reset held asserted: outputs stay at their reset values and frame_start stays 1.

Optional Feature:
- Macro: DISP_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: in S_DIG_T, an1 stays 1 when val_out < 10, so the tens digit is blank. Timing and sel_units are unchanged.
- Undefined: the tens digit is always lit in S_DIG_T and shows 0 for values 0..9.

Decomposition:
- Shared package disp_pkg:
  - typedef enum logic [1:0] scan_state_t {S_GAP_TU, S_DIG_U, S_GAP_UT, S_DIG_T};
  - localparams ANODE_ON=1'b0, ANODE_OFF=1'b1, SEL_UNITS=1'b1, SEL_TENS=1'b0.
- Sub-module sync_bus (parameters WIDTH, STAGES): multi-flop bus synchronizer with synchronous active-high reset to 0. It is instantiated once with WIDTH=4.

Test Plan (DIGIT_CYCLES=8, GAP_CYCLES=2, SYNC_STAGES=2):
- Reset then release with sw_in=4'd13:
  - First frame: val_out=0.
  - Next frame_start: val_out=13.
  - Anode sequence: 2 cycles both 1, 8 cycles an0=0, 2 cycles both 1, 8 cycles an1=0; period 20.
- Every cycle over 5 frames: never an0=0 && an1=0. sel_units toggles only when an0=an1=1.
- Change sw_in 13->7 in the middle of S_DIG_U: val_out stays 13 until the next frame_start edge, then becomes 7.
- Assert rst for 1 cycle during S_DIG_T: next edge gives an0=an1=1, sel_units=1, val_out=0. Lit units resume exactly 2 cycles after release.
- Macro defined, sw_in=5: an1 never 0, an0 lit 8 of every 20 cycles. Then sw_in=12: an1 lit 8 cycles per frame.
- Macro undefined, sw_in=5: an1=0 for 8 cycles per frame with sel_units=0.

Source files
------------

// File: rtl/disp_scan_pkg.sv
// Shared types and constants for the two-digit display scan controller.
package disp_pkg;

  // Scan phases in cycle order: dark gap, units lit, dark gap, tens lit.
  typedef enum logic [1:0] {
    S_GAP_TU,
    S_DIG_U,
    S_GAP_UT,
    S_DIG_T
  } scan_state_t;

  // Anodes are active-low.
  localparam logic ANODE_ON  = 1'b0;
  localparam logic ANODE_OFF = 1'b1;

  // Decoder nibble select.
  localparam logic SEL_UNITS = 1'b1;
  localparam logic SEL_TENS  = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Display-side bundle: switch input, decoder value/select, anodes, frame pulse.
// master = scan controller, slave = whatever feeds switches and consumes outputs.
interface disp_scan_if;
  logic [3:0] sw_in;
  logic [3:0] val_out;
  logic       sel_units;
  logic       an0;
  logic       an1;
  logic       frame_start;

  modport master (
    input  sw_in,
    output val_out, sel_units, an0, an1, frame_start
  );

  modport slave (
    output sw_in,
    input  val_out, sel_units, an0, an1, frame_start
  );
endinterface

// File: rtl/disp_scan_sync.sv
// Multi-flop bus synchronizer, synchronous active-high reset to zero.
// No debounce: each bit is simply delayed by STAGES flops.
module sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_reg;

  // Shift the raw input through the flop chain; stage 0 samples the async pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/disp_scan.sv
// Two-digit 7-segment scan controller with dead-time gaps between digits.
// Optional macro DISP_SCAN_LEADING_ZERO_BLANK_EN: blank the tens digit when the
// frozen value is below 10 (timing and select unchanged).
module disp_scan
  import disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 500,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  disp_scan_if.master bus
);

  localparam int CW = $clog2(max_int(DIGIT_CYCLES, GAP_CYCLES));
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  logic [3:0]  sync_val;
  scan_state_t state_reg;
  logic [CW-1:0] count_reg;
  logic [3:0]  val_reg;
  logic        sel_reg;
  logic        an0_reg;
  logic        an1_reg;
  logic        fs_reg;
  logic        tens_anode;

  sync_bus #(
    .WIDTH (4),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.sw_in),
    .q  (sync_val)
  );

  // The frozen value is stable for the whole frame, so it can decide the tens
  // anode at the moment the tens phase is entered.
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
  assign tens_anode = (val_reg < 4'd10) ? ANODE_OFF : ANODE_ON;
`else
  assign tens_anode = ANODE_ON;
`endif

  // Scan FSM: every output is set on the edge that enters the new phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_GAP_TU;
      count_reg <= '0;
      val_reg   <= '0;
      sel_reg   <= SEL_UNITS;
      an0_reg   <= ANODE_OFF;
      an1_reg   <= ANODE_OFF;
      fs_reg    <= 1'b1;
    end else begin
      fs_reg <= 1'b0;
      unique case (state_reg)
        S_GAP_TU: begin
          if (count_reg == GAP_LAST) begin
            state_reg <= S_DIG_U;
            count_reg <= '0;
            an0_reg   <= ANODE_ON;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        S_DIG_U: begin
          if (count_reg == DIG_LAST) begin
            state_reg <= S_GAP_UT;
            count_reg <= '0;
            an0_reg   <= ANODE_OFF;
            sel_reg   <= SEL_TENS;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        S_GAP_UT: begin
          if (count_reg == GAP_LAST) begin
            state_reg <= S_DIG_T;
            count_reg <= '0;
            an1_reg   <= tens_anode;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        S_DIG_T: begin
          if (count_reg == DIG_LAST) begin
            state_reg <= S_GAP_TU;
            count_reg <= '0;
            an1_reg   <= ANODE_OFF;
            sel_reg   <= SEL_UNITS;
            val_reg   <= sync_val;
            fs_reg    <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.val_out     = val_reg;
  assign bus.sel_units   = sel_reg;
  assign bus.an0         = an0_reg;
  assign bus.an1         = an1_reg;
  assign bus.frame_start = fs_reg;

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan: a frame-phase reference model predicts
// every output on every cycle, plus directed checks on the key scenarios.
module tb_disp_scan;
  localparam int D = 8;
  localparam int G = 2;
  localparam int S = 2;
  localparam int P = 2 * (D + G);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disp_scan_if bus ();

  disp_scan #(
    .DIGIT_CYCLES(D),
    .GAP_CYCLES  (G),
    .SYNC_STAGES (S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the frame, frozen value, sync pipeline.
  int         t = 0;
  logic [3:0] mval = 4'd0;
  logic       mfs = 1'b1;
  logic [3:0] q[$];
  logic       prev_sel = 1'b1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
    end
  endtask

  task automatic tick();
    logic [3:0] pre;
    int e_sel, e_an0, e_an1;
    pre = q[0];
    @(posedge clk);
    if (rst) begin
      t = 0;
      mval = 4'd0;
      mfs = 1'b1;
      q.delete();
      repeat (S) q.push_back(4'd0);
    end else begin
      t = (t + 1) % P;
      mfs = (t == 0);
      if (t == 0) mval = pre;
      q.push_back(bus.sw_in);
      void'(q.pop_front());
    end
    #1;
    e_sel = (t < G + D) ? 1 : 0;
    e_an0 = (t >= G && t < G + D) ? 0 : 1;
    e_an1 = (t >= 2 * G + D) ? 0 : 1;
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
    if (mval < 4'd10) e_an1 = 1;
`endif
    check_val("val_out", int'(bus.val_out), int'(mval));
    check_val("sel_units", int'(bus.sel_units), e_sel);
    check_val("an0", int'(bus.an0), e_an0);
    check_val("an1", int'(bus.an1), e_an1);
    check_val("frame_start", int'(bus.frame_start), int'(mfs));
    check_val("no_overlap", int'(bus.an0 | bus.an1), 1);
    if (bus.sel_units !== prev_sel) check_val("sel_dark", int'(bus.an0 & bus.an1), 1);
    prev_sel = bus.sel_units;
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i <= P && t != phase; i++) tick();
    check_val("reach_phase", t, phase);
  endtask

  int c0, c1;

  initial begin
    repeat (S) q.push_back(4'd0);
    bus.sw_in = 4'd0;
    rst = 1'b1;
    tick();
    tick();
    check_val("rst_fs_held", int'(bus.frame_start), 1);

    // Release with 13: first frame shows 0, next frame 13.
    bus.sw_in = 4'd13;
    rst = 1'b0;
    check_val("frame1_val", int'(bus.val_out), 0);
    repeat (P) tick();
    check_val("frame2_val", int'(bus.val_out), 13);
    check_val("frame2_fs", int'(bus.frame_start), 1);

    // Mid-units switch change must not tear the displayed pair.
    run_to(G + 3);
    bus.sw_in = 4'd7;
    run_to(P - 1);
    check_val("val_hold", int'(bus.val_out), 13);
    tick();
    check_val("val_new", int'(bus.val_out), 7);

    // One-cycle reset during the tens phase.
    run_to(2 * G + D + 2);
    rst = 1'b1;
    tick();
    check_val("rst_an0", int'(bus.an0), 1);
    check_val("rst_an1", int'(bus.an1), 1);
    check_val("rst_sel", int'(bus.sel_units), 1);
    check_val("rst_val", int'(bus.val_out), 0);
    rst = 1'b0;
    repeat (G - 1) tick();
    check_val("still_dark", int'(bus.an0), 1);
    tick();
    check_val("units_resume", int'(bus.an0), 0);

    // Value 5: tens blanked only when the blanking option is built in.
    bus.sw_in = 4'd5;
    run_to(0);
    repeat (P) tick();
    c0 = 0; c1 = 0;
    for (int i = 0; i < P; i++) begin
      tick();
      if (bus.an0 == 1'b0) c0++;
      if (bus.an1 == 1'b0) c1++;
    end
    check_val("v5_an0_lit", c0, D);
`ifdef DISP_SCAN_LEADING_ZERO_BLANK_EN
    check_val("v5_an1_lit", c1, 0);
`else
    check_val("v5_an1_lit", c1, D);
`endif

    // Value 12: tens always lit.
    bus.sw_in = 4'd12;
    repeat (P) tick();
    c1 = 0;
    for (int i = 0; i < P; i++) begin
      tick();
      if (bus.an1 == 1'b0) c1++;
    end
    check_val("v12_an1_lit", c1, D);

    // Randomized switch activity with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) bus.sw_in = 4'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (P) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
